// File: rtl/bpu_gshare_if.sv
// Pipeline-facing signals of the gshare branch predictor: the IF lookup,
// the EX resolution and the stall input. The pipeline is master; the
// predictor is slave.
interface bpu_gshare_if;
  logic        if_valid;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        suspend;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        ex_branch;
  logic        ex_jump;
  logic        ex_is_call;
  logic        ex_is_ret;
  logic        real_taken;
  logic [31:0] real_target;
  logic        pred_error;

  modport master (
    output if_valid, if_pc, suspend, ex_valid, ex_pc, ex_branch, ex_jump,
           ex_is_call, ex_is_ret, real_taken, real_target,
    input  pred_taken, pred_target, pred_error
  );

  modport slave (
    input  if_valid, if_pc, suspend, ex_valid, ex_pc, ex_branch, ex_jump,
           ex_is_call, ex_is_ret, real_taken, real_target,
    output pred_taken, pred_target, pred_error
  );
endinterface

// File: rtl/bpu_gshare.sv
// gshare direction predictor with a tagged BTB, speculative global history
// and a circular return-address stack. Prediction is combinational in IF;
// per-instruction checkpoints ride to EX, where mispredicts repair the
// speculative state and resolved branches train the tables.
module bpu_gshare #(
  parameter int PHT_IDX_W = 10,
  parameter int BTB_IDX_W = 8,
  parameter int TAG_W     = 8,
  parameter int GHR_W     = 8,
  parameter int RAS_DEPTH = 8
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  bpu_gshare_if.slave bus
);
  localparam int PHT_N     = 1 << PHT_IDX_W;
  localparam int BTB_N     = 1 << BTB_IDX_W;
  localparam int RAS_PTR_W = $clog2(RAS_DEPTH);

  localparam logic [RAS_PTR_W-1:0] PTR_ONE  = RAS_PTR_W'(1);
  localparam logic [RAS_PTR_W:0]   CNT_ONE  = (RAS_PTR_W+1)'(1);
  localparam logic [RAS_PTR_W:0]   CNT_FULL = (RAS_PTR_W+1)'(RAS_DEPTH);

  // BTB entry types
  localparam logic [1:0] T_BRANCH = 2'd0;
  localparam logic [1:0] T_JUMP   = 2'd1;
  localparam logic [1:0] T_CALL   = 2'd2;
  localparam logic [1:0] T_RET    = 2'd3;

  // Checkpoint of everything needed to judge and repair one instruction.
  typedef struct packed {
    logic [PHT_IDX_W-1:0] pht_idx;
    logic                 taken;
    logic [31:0]          target;
    logic [GHR_W-1:0]     ghr;
    logic [RAS_PTR_W-1:0] ras_ptr;
    logic [RAS_PTR_W:0]   ras_cnt;
  } meta_t;

  logic [1:0]           pht     [PHT_N];
  logic                 btb_vld [BTB_N];
  logic [TAG_W-1:0]     btb_tag [BTB_N];
  logic [31:0]          btb_tgt [BTB_N];
  logic [1:0]           btb_typ [BTB_N];
  logic [31:0]          ras     [RAS_DEPTH];

  logic [GHR_W-1:0]     spec_ghr;
  logic [RAS_PTR_W-1:0] ras_ptr;
  logic [RAS_PTR_W:0]   ras_cnt;

  meta_t if_meta, id_meta, ex_meta;

  // IF lookup
  logic [BTB_IDX_W-1:0] if_btb_idx;
  logic [TAG_W-1:0]     if_tag;
  logic [PHT_IDX_W-1:0] if_pht_idx;
  logic                 if_hit;
  logic [1:0]           if_type;
  logic [31:0]          if_pc_p4;
  logic [RAS_PTR_W-1:0] ras_top_ptr;
  logic                 ras_empty;
  logic                 pred_taken_c;
  logic [31:0]          pred_target_c;

  assign if_btb_idx  = bus.if_pc[BTB_IDX_W+1:2];
  assign if_tag      = bus.if_pc[31:32-TAG_W];
  assign if_pht_idx  = bus.if_pc[PHT_IDX_W+1:2] ^ PHT_IDX_W'(spec_ghr);
  assign if_hit      = btb_vld[if_btb_idx] && (btb_tag[if_btb_idx] == if_tag);
  assign if_type     = btb_typ[if_btb_idx];
  assign if_pc_p4    = bus.if_pc + 32'd4;
  assign ras_top_ptr = ras_ptr - PTR_ONE;
  assign ras_empty   = (ras_cnt == '0);

  // Direction and next-PC; a return with an empty stack falls through.
  always_comb begin
    pred_taken_c  = 1'b0;
    pred_target_c = if_pc_p4;
    if (if_hit) begin
      if (if_type == T_RET) begin
        if (!ras_empty) begin
          pred_taken_c  = 1'b1;
          pred_target_c = ras[ras_top_ptr];
        end
      end else if ((if_type != T_BRANCH) || pht[if_pht_idx][1]) begin
        pred_taken_c  = 1'b1;
        pred_target_c = btb_tgt[if_btb_idx];
      end
    end
  end

  assign bus.pred_taken  = pred_taken_c;
  assign bus.pred_target = pred_target_c;

  // Snapshot taken before this fetch's own speculative update.
  always_comb begin
    if_meta         = '0;
    if_meta.pht_idx = if_pht_idx;
    if_meta.taken   = pred_taken_c;
    if_meta.target  = pred_target_c;
    if_meta.ghr     = spec_ghr;
    if_meta.ras_ptr = ras_ptr;
    if_meta.ras_cnt = ras_cnt;
  end

  // EX resolution
  logic        ex_is_bj;
  logic        dir_err;
  logic        tgt_err;
  logic        pred_err;
  logic [31:0] ex_pc_p4;
  logic [1:0]  ex_type;

  assign ex_is_bj = bus.ex_branch | bus.ex_jump;
  assign dir_err  = ex_meta.taken != (ex_is_bj & bus.real_taken);
  assign tgt_err  = ex_meta.taken & bus.real_taken & (ex_meta.target != bus.real_target);
  assign pred_err = bus.ex_valid & ~cpu_rst & (dir_err | tgt_err);
  assign ex_pc_p4 = bus.ex_pc + 32'd4;
  assign ex_type  = bus.ex_is_ret  ? T_RET  :
                    bus.ex_is_call ? T_CALL :
                    bus.ex_jump    ? T_JUMP : T_BRANCH;

  assign bus.pred_error = pred_err;

  // Next speculative history / stack state: EX repair beats the IF update.
  logic [GHR_W-1:0]     ghr_nxt;
  logic [RAS_PTR_W-1:0] ptr_nxt;
  logic [RAS_PTR_W:0]   cnt_nxt;
  logic                 ras_we;
  logic [RAS_PTR_W-1:0] ras_widx;
  logic [31:0]          ras_wdata;

  // Compute repaired or speculatively advanced GHR and RAS state.
  always_comb begin
    ghr_nxt   = spec_ghr;
    ptr_nxt   = ras_ptr;
    cnt_nxt   = ras_cnt;
    ras_we    = 1'b0;
    ras_widx  = ras_ptr;
    ras_wdata = if_pc_p4;
    if (pred_err) begin
      ghr_nxt = bus.ex_branch ? {ex_meta.ghr[GHR_W-2:0], bus.real_taken} : ex_meta.ghr;
      ptr_nxt = ex_meta.ras_ptr;
      cnt_nxt = ex_meta.ras_cnt;
      if (bus.ex_is_ret) begin
        if (ex_meta.ras_cnt != '0) begin
          ptr_nxt = ex_meta.ras_ptr - PTR_ONE;
          cnt_nxt = ex_meta.ras_cnt - CNT_ONE;
        end
      end else if (bus.ex_is_call) begin
        ras_we    = 1'b1;
        ras_widx  = ex_meta.ras_ptr;
        ras_wdata = ex_pc_p4;
        ptr_nxt   = ex_meta.ras_ptr + PTR_ONE;
        if (ex_meta.ras_cnt != CNT_FULL) cnt_nxt = ex_meta.ras_cnt + CNT_ONE;
      end
    end else if (bus.if_valid && !bus.suspend && if_hit) begin
      case (if_type)
        T_BRANCH: ghr_nxt = {spec_ghr[GHR_W-2:0], pred_taken_c};
        T_CALL: begin
          ras_we  = 1'b1;
          ptr_nxt = ras_ptr + PTR_ONE;
          if (ras_cnt != CNT_FULL) cnt_nxt = ras_cnt + CNT_ONE;
        end
        T_RET: begin
          if (!ras_empty) begin
            ptr_nxt = ras_top_ptr;
            cnt_nxt = ras_cnt - CNT_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  // Register speculative history and stack pointers.
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      spec_ghr <= '0;
      ras_ptr  <= '0;
      ras_cnt  <= '0;
    end else begin
      spec_ghr <= ghr_nxt;
      ras_ptr  <= ptr_nxt;
      ras_cnt  <= cnt_nxt;
    end
  end

  // Return-stack storage; stale entries are unreachable once count is zero.
  always_ff @(posedge cpu_clk) begin
    if (!cpu_rst && ras_we) ras[ras_widx] <= ras_wdata;
  end

  // Train the 2-bit counter of a resolved conditional branch.
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      for (int i = 0; i < PHT_N; i++) pht[i] <= 2'b01;
    end else if (bus.ex_valid && bus.ex_branch) begin
      if (bus.real_taken && (pht[ex_meta.pht_idx] != 2'b11))
        pht[ex_meta.pht_idx] <= pht[ex_meta.pht_idx] + 2'b01;
      else if (!bus.real_taken && (pht[ex_meta.pht_idx] != 2'b00))
        pht[ex_meta.pht_idx] <= pht[ex_meta.pht_idx] - 2'b01;
    end
  end

  // BTB valid bits: cleared on reset, set by any taken resolution.
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      for (int i = 0; i < BTB_N; i++) btb_vld[i] <= 1'b0;
    end else if (bus.ex_valid && ex_is_bj && bus.real_taken) begin
      btb_vld[bus.ex_pc[BTB_IDX_W+1:2]] <= 1'b1;
    end
  end

  // BTB payload: allocate or refresh tag, target and type on a taken resolution.
  always_ff @(posedge cpu_clk) begin
    if (!cpu_rst && bus.ex_valid && ex_is_bj && bus.real_taken) begin
      btb_tag[bus.ex_pc[BTB_IDX_W+1:2]] <= bus.ex_pc[31:32-TAG_W];
      btb_tgt[bus.ex_pc[BTB_IDX_W+1:2]] <= bus.real_target;
      btb_typ[bus.ex_pc[BTB_IDX_W+1:2]] <= ex_type;
    end
  end

  // Advance checkpoints IF->ID->EX; a mispredict squashes the ID slot.
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      id_meta <= '0;
      ex_meta <= '0;
    end else begin
      if (!bus.suspend) begin
        ex_meta <= id_meta;
        id_meta <= if_meta;
      end
      if (pred_err) id_meta.taken <= 1'b0;
    end
  end
endmodule

// File: tb/tb_bpu_gshare.sv
// Self-checking bench for bpu_gshare: a behavioural model of the predictor
// is stepped alongside the DUT every cycle, under directed scenarios and a
// randomized pipeline that follows predictions and redirects on mispredicts.
module tb_bpu_gshare;
  logic cpu_clk = 1'b0;
  logic cpu_rst;

  bpu_gshare_if bus ();

  bpu_gshare dut (
    .cpu_clk (cpu_clk),
    .cpu_rst (cpu_rst),
    .bus     (bus)
  );

  always #5 cpu_clk = ~cpu_clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
  endtask

  // Reference model state
  typedef struct {
    int          pidx;
    bit          pt;
    logic [31:0] ptgt;
    int          ghr;
    int          rptr;
    int          rcnt;
  } meta_t;

  int          m_pht   [1024];
  bit          m_bv    [256];
  int          m_btag  [256];
  logic [31:0] m_btgt  [256];
  int          m_btype [256];
  logic [31:0] m_ras   [8];
  int          m_ghr, m_rptr, m_rcnt;
  meta_t       m_id, m_ex;

  logic        o_pt, o_err;
  logic [31:0] o_tgt;
  bit          e_pt, e_err;
  logic [31:0] e_tgt;

  task automatic model_reset();
    for (int i = 0; i < 1024; i++) m_pht[i] = 1;
    for (int i = 0; i < 256; i++) m_bv[i] = 1'b0;
    m_ghr  = 0;
    m_rptr = 0;
    m_rcnt = 0;
    m_id   = '{0, 1'b0, 32'h0, 0, 0, 0};
    m_ex   = '{0, 1'b0, 32'h0, 0, 0, 0};
  endtask

  // One clock: drive, predict with the model, compare, advance the model.
  // fl = {branch, jump, call, ret}
  task automatic cyc(input bit rst, input bit ifv, input logic [31:0] ipc, input bit susp,
                     input bit exv, input logic [31:0] epc, input bit [3:0] fl,
                     input bit rtk, input logic [31:0] rtgt);
    bit    br, jp, cl, rt, hit;
    int    bi, ei, pidx, typ;
    meta_t snap;
    {br, jp, cl, rt} = fl;
    cpu_rst         = rst;
    bus.if_valid    = ifv;
    bus.if_pc       = ipc;
    bus.suspend     = susp;
    bus.ex_valid    = exv;
    bus.ex_pc       = epc;
    bus.ex_branch   = br;
    bus.ex_jump     = jp;
    bus.ex_is_call  = cl;
    bus.ex_is_ret   = rt;
    bus.real_taken  = rtk;
    bus.real_target = rtgt;
    #2;
    bi    = int'(ipc[9:2]);
    hit   = m_bv[bi] && (m_btag[bi] == int'(ipc[31:24]));
    typ   = m_btype[bi];
    pidx  = int'(ipc[11:2]) ^ m_ghr;
    e_pt  = hit && (typ != 0 || m_pht[pidx] >= 2);
    if (hit && typ == 3 && m_rcnt == 0) e_pt = 1'b0;
    e_tgt = !e_pt ? ipc + 32'd4 : (typ == 3 ? m_ras[(m_rptr + 7) % 8] : m_btgt[bi]);
    e_err = exv && !rst &&
            ((m_ex.pt != ((br || jp) && rtk)) || (m_ex.pt && rtk && m_ex.ptgt != rtgt));
    o_pt  = bus.pred_taken;
    o_tgt = bus.pred_target;
    o_err = bus.pred_error;
    check("pred_taken", o_pt, e_pt);
    check("pred_target", o_tgt, e_tgt);
    check("pred_error", o_err, e_err);

    snap = '{pidx, e_pt, e_tgt, m_ghr, m_rptr, m_rcnt};
    if (rst) begin
      model_reset();
    end else begin
      if (exv && (br || jp)) begin
        if (br) begin
          if (rtk && m_pht[m_ex.pidx] < 3) m_pht[m_ex.pidx]++;
          if (!rtk && m_pht[m_ex.pidx] > 0) m_pht[m_ex.pidx]--;
        end
        if (rtk) begin
          ei          = int'(epc[9:2]);
          m_bv[ei]    = 1'b1;
          m_btag[ei]  = int'(epc[31:24]);
          m_btgt[ei]  = rtgt;
          m_btype[ei] = rt ? 3 : cl ? 2 : jp ? 1 : 0;
        end
      end
      if (e_err) begin
        m_ghr  = br ? (((m_ex.ghr << 1) | int'(rtk)) & 255) : m_ex.ghr;
        m_rptr = m_ex.rptr;
        m_rcnt = m_ex.rcnt;
        if (rt) begin
          if (m_rcnt > 0) begin
            m_rptr = (m_rptr + 7) % 8;
            m_rcnt--;
          end
        end else if (cl) begin
          m_ras[m_rptr] = epc + 32'd4;
          m_rptr = (m_rptr + 1) % 8;
          if (m_rcnt < 8) m_rcnt++;
        end
      end else if (ifv && !susp && hit) begin
        if (typ == 0) m_ghr = ((m_ghr << 1) | int'(e_pt)) & 255;
        else if (typ == 2) begin
          m_ras[m_rptr] = ipc + 32'd4;
          m_rptr = (m_rptr + 1) % 8;
          if (m_rcnt < 8) m_rcnt++;
        end else if (typ == 3 && m_rcnt > 0) begin
          m_rptr = (m_rptr + 7) % 8;
          m_rcnt--;
        end
      end
      if (!susp) begin
        m_ex = m_id;
        m_id = snap;
      end
      if (e_err) m_id.pt = 1'b0;
    end
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 4'b0000, 1'b0, 32'h0);
  endtask

  // Random program: kind per word slot (0 none, 1 branch, 2 jump, 3 call, 4 ret)
  int          kind    [64];
  logic [31:0] tgt_tab [64];

  function automatic logic [31:0] rand_pc();
    logic [31:0] base;
    base = ($urandom_range(0, 7) == 0) ? 32'h5000_1000 : 32'h0000_1000;
    return base + 32'(4 * $urandom_range(0, 63));
  endfunction

  logic [31:0] if_pc_s, id_pc_s, ex_pc_s;
  bit          sv_if, sv_id, sv_ex;

  initial begin
    bit          s_pt;
    logic [31:0] s_tgt;
    model_reset();
    cpu_rst         = 1'b1;
    bus.if_valid    = 1'b0;
    bus.if_pc       = '0;
    bus.suspend     = 1'b0;
    bus.ex_valid    = 1'b0;
    bus.ex_pc       = '0;
    bus.ex_branch   = 1'b0;
    bus.ex_jump     = 1'b0;
    bus.ex_is_call  = 1'b0;
    bus.ex_is_ret   = 1'b0;
    bus.real_taken  = 1'b0;
    bus.real_target = '0;
    @(posedge cpu_clk);
    #1;
    cyc(1'b1, 1'b1, 32'h1000, 1'b0, 1'b1, 32'h1000, 4'b1000, 1'b1, 32'h2000);
    check("rst_error_forced", o_err, 1'b0);

    // Cold fetch, taken branch resolves, then retrain until GHR wraps to 0.
    cyc(1'b0, 1'b1, 32'h1000, 1'b0, 1'b0, 32'h0, 4'b0000, 1'b0, 32'h0);
    check("cold_taken", o_pt, 1'b0);
    check("cold_target", o_tgt, 32'h1004);
    idle();
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h1000, 4'b1000, 1'b1, 32'h2000);
    check("first_mispredict", o_err, 1'b1);
    for (int i = 0; i < 8; i++)
      cyc(1'b0, 1'b1, 32'h1000, 1'b0, 1'b0, 32'h0, 4'b0000, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 32'h1000, 1'b0, 1'b0, 32'h0, 4'b0000, 1'b0, 32'h0);
    check("trained_taken", o_pt, 1'b1);
    check("trained_target", o_tgt, 32'h2000);

    // RAS overflow: RAS_DEPTH+1 nested calls, then RAS_DEPTH+1 returns.
    for (int i = 0; i < 9; i++)
      cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h3040 + 32'(4 * i), 4'b0110, 1'b1, 32'h3100);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h3100, 4'b0101, 1'b1, 32'h7000);
    idle();
    for (int i = 0; i < 9; i++)
      cyc(1'b0, 1'b1, 32'h3040 + 32'(4 * i), 1'b0, 1'b0, 32'h0, 4'b0000, 1'b0, 32'h0);
    for (int j = 0; j < 9; j++) begin
      cyc(1'b0, 1'b1, 32'h3100, 1'b0, 1'b0, 32'h0, 4'b0000, 1'b0, 32'h0);
      check("ret_taken", o_pt, (j < 8) ? 1'b1 : 1'b0);
      check("ret_target", o_tgt, (j < 8) ? 32'h3040 + 32'(4 * (8 - j)) + 32'd4 : 32'h3104);
    end

    // Stall on a branch fetch; checkpoint reaching EX must match the pre-stall prediction.
    cyc(1'b0, 1'b1, 32'h1000, 1'b1, 1'b0, 32'h0, 4'b0000, 1'b0, 32'h0);
    s_pt  = o_pt;
    s_tgt = o_tgt;
    cyc(1'b0, 1'b1, 32'h1000, 1'b1, 1'b0, 32'h0, 4'b0000, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 32'h1000, 1'b1, 1'b0, 32'h0, 4'b0000, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 32'h1000, 1'b0, 1'b0, 32'h0, 4'b0000, 1'b0, 32'h0);
    check("stall_same_pred", o_tgt, s_tgt);
    idle();
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h1000, 4'b1000, s_pt, s_tgt);
    check("stall_meta_ok", o_err, 1'b0);

    // Randomized pipeline following predictions, with a mid-run reset.
    for (int i = 0; i < 64; i++) begin
      kind[i]    = $urandom_range(0, 4);
      tgt_tab[i] = 32'h1000 + 32'(4 * $urandom_range(0, 63));
    end
    if_pc_s = 32'h1000;
    id_pc_s = '0;
    ex_pc_s = '0;
    sv_if   = 1'b1;
    sv_id   = 1'b0;
    sv_ex   = 1'b0;
    for (int it = 0; it < 3000; it++) begin
      bit          susp, rtk;
      bit [3:0]    fl;
      int          k;
      logic [31:0] redir;
      if (it == 1500) begin
        cyc(1'b1, 1'b1, if_pc_s, 1'b0, 1'b0, 32'h0, 4'b0000, 1'b0, 32'h0);
        sv_id = 1'b0;
        sv_ex = 1'b0;
        continue;
      end
      susp = ($urandom_range(0, 9) == 0);
      k    = kind[ex_pc_s[7:2]];
      fl   = {k == 1, k >= 2, k == 3, k == 4};
      rtk  = (k == 1) ? ($urandom_range(0, 2) != 0) : (k >= 2);
      cyc(1'b0, sv_if, if_pc_s, susp, sv_ex && !susp, ex_pc_s, fl, rtk, tgt_tab[ex_pc_s[7:2]]);
      if (!susp) begin
        redir   = rtk ? tgt_tab[ex_pc_s[7:2]] : ex_pc_s + 32'd4;
        ex_pc_s = id_pc_s;
        sv_ex   = sv_id && !e_err;
        id_pc_s = if_pc_s;
        sv_id   = sv_if && !e_err;
        if (e_err) if_pc_s = redir;
        else if ($urandom_range(0, 3) == 0) if_pc_s = rand_pc();
        else if_pc_s = e_tgt;
        sv_if = ($urandom_range(0, 9) != 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
